// File: rtl/reg_dump_reader_pkg.sv
// Shared core constants for the 16-bit register file and its readers.
// Holds default geometry and the dump-reader state encoding.
package reg_dump_reader_pkg;

    localparam int DATA_W_D   = 16;
    localparam int ADDR_W_D   = 3;
    localparam int NUM_REGS_D = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register file read port and streams each word with its index.
// Read-only: prefetches idx+1 so a word can be emitted every cycle.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_W   = DATA_W_D,
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int ADDR_W   = ADDR_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;

    logic [ADDR_W-1:0] w_idx_nxt;
    logic              w_last;
    logic              w_hs;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_idx_nxt = r_idx + ADDR_W'(1);
    assign w_last    = (r_idx == LAST);
    assign w_hs      = r_valid & out_ready;

    // Compare before increment so a full-range index never wraps.
    always_comb begin
        w_rd_addr = '0;
        case (r_state)
            LOAD:    w_rd_addr = r_idx;
            STREAM:  w_rd_addr = w_last ? '0 : w_idx_nxt;
            default: w_rd_addr = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_data  <= rd_data;
                        r_addr  <= r_idx;
                        r_valid <= 1'b1;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_hs) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_data <= rd_data;
                            r_addr <= w_idx_nxt;
                            r_idx  <= w_idx_nxt;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_addr   = w_rd_addr;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_addr  = r_addr;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: 8-register and 4-register instances.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, abort, ready;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        valid, busy, done;
    logic [15:0] data;
    logic [2:0]  addr;
    logic [15:0] rf [8];

    logic        start4, abort4, ready4;
    logic [1:0]  rd_addr4;
    logic [15:0] rd_data4;
    logic        valid4, busy4, done4;
    logic [15:0] data4;
    logic [1:0]  addr4;
    logic [15:0] rf4 [4];

    assign rd_data  = rf[rd_addr];
    assign rd_data4 = rf4[rd_addr4];

    reg_dump_reader u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(valid), .out_ready(ready),
        .out_data(data), .out_addr(addr),
        .busy(busy), .done(done)
    );

    reg_dump_reader #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .rd_addr(rd_addr4), .rd_data(rd_data4),
        .out_valid(valid4), .out_ready(ready4),
        .out_data(data4), .out_addr(addr4),
        .busy(busy4), .done(done4)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic beat(input string tag, input int a, input logic [15:0] d);
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk({tag, " addr"}, 32'(addr), 32'(a));
        chk({tag, " data"}, 32'(data), 32'(d));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    endtask

    initial begin
        int          exp_i;
        int          done_n;
        bit          have_prev;
        logic [15:0] prev_d;
        logic [2:0]  prev_a;

        rst = 1'b1;
        start = 0; abort = 0; ready = 0;
        start4 = 0; abort4 = 0; ready4 = 0;
        preload();
        for (int i = 0; i < 4; i++) rf4[i] = 16'h2000 + 16'(i);

        #3;
        chk("rst valid", 32'(valid), 0);
        chk("rst data", 32'(data), 0);
        chk("rst addr", 32'(addr), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst rd_addr", 32'(rd_addr), 0);
        tick();
        rst = 1'b0;
        tick();

        // Continuous ready: eight back-to-back beats, then done.
        ready = 1'b1;
        pulse_start();
        chk("t1 load busy", 32'(busy), 1);
        chk("t1 load valid", 32'(valid), 0);
        chk("t1 load rd_addr", 32'(rd_addr), 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            beat($sformatf("t1 beat%0d", i), i, 16'h1000 + 16'(i));
            tick();
        end
        chk("t1 done", 32'(done), 1);
        chk("t1 end valid", 32'(valid), 0);
        chk("t1 end busy", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1 restart on done busy", 32'(busy), 1);
        chk("t1 done one cycle", 32'(done), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t1 abort load busy", 32'(busy), 0);
        chk("t1 abort load valid", 32'(valid), 0);
        chk("t1 abort load done", 32'(done), 0);

        // Ready pattern 1,0,0: stalls must hold the word steady.
        pulse_start();
        exp_i = 0;
        done_n = 0;
        have_prev = 0;
        prev_d = '0;
        prev_a = '0;
        for (int k = 0; k < 40; k++) begin
            if (have_prev) begin
                chk("t2 hold valid", 32'(valid), 1);
                chk("t2 hold data", 32'(data), 32'(prev_d));
                chk("t2 hold addr", 32'(addr), 32'(prev_a));
            end
            if (done) done_n++;
            ready = (k % 3 == 0);
            have_prev = 0;
            if (valid && ready) begin
                chk("t2 addr", 32'(addr), 32'(exp_i));
                chk("t2 data", 32'(data), 32'h1000 + 32'(exp_i));
                exp_i++;
            end else if (valid) begin
                have_prev = 1;
                prev_d = data;
                prev_a = addr;
            end
            tick();
        end
        chk("t2 beats", 32'(exp_i), 8);
        chk("t2 done count", 32'(done_n), 1);
        chk("t2 busy", 32'(busy), 0);

        // Late write is visible only to registers not yet captured.
        ready = 1'b1;
        pulse_start();
        tick();
        beat("t3 b0", 0, 16'h1000);
        tick();
        beat("t3 b1", 1, 16'h1001);
        tick();
        beat("t3 b2", 2, 16'h1002);
        ready = 1'b0;
        rf[5] = 16'hBEEF;
        rf[1] = 16'hDEAD;
        tick();
        beat("t3 b2 stall", 2, 16'h1002);
        ready = 1'b1;
        tick();
        beat("t3 b3", 3, 16'h1003);
        tick();
        beat("t3 b4", 4, 16'h1004);
        tick();
        beat("t3 b5", 5, 16'hBEEF);
        tick();
        beat("t3 b6", 6, 16'h1006);
        tick();
        beat("t3 b7", 7, 16'h1007);
        tick();
        chk("t3 done", 32'(done), 1);
        preload();

        // Abort during word 3 with ready high.
        pulse_start();
        tick();
        for (int i = 0; i < 3; i++) tick();
        beat("t4 b3", 3, 16'h1003);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4 abort valid", 32'(valid), 0);
        chk("t4 abort busy", 32'(busy), 0);
        chk("t4 abort done", 32'(done), 0);
        tick();
        chk("t4 no late done", 32'(done), 0);
        pulse_start();
        tick();
        for (int i = 0; i < 8; i++) begin
            beat($sformatf("t4 redump%0d", i), i, 16'h1000 + 16'(i));
            tick();
        end
        chk("t4 redump done", 32'(done), 1);

        // Start pulsed mid-dump is ignored.
        pulse_start();
        tick();
        for (int i = 0; i < 8; i++) begin
            beat($sformatf("t5 b%0d", i), i, 16'h1000 + 16'(i));
            start = (i == 3);
            tick();
        end
        start = 1'b0;
        chk("t5 done", 32'(done), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5 no extra valid", 32'(valid), 0);
            chk("t5 no extra busy", 32'(busy), 0);
        end

        // Asynchronous reset between edges mid-stream.
        pulse_start();
        tick();
        beat("t5r b0", 0, 16'h1000);
        tick();
        beat("t5r b1", 1, 16'h1001);
        #2 rst = 1'b1;
        #1;
        chk("t5r valid", 32'(valid), 0);
        chk("t5r data", 32'(data), 0);
        chk("t5r addr", 32'(addr), 0);
        chk("t5r busy", 32'(busy), 0);
        chk("t5r rd_addr", 32'(rd_addr), 0);
        #1 rst = 1'b0;
        tick();
        chk("t5r idle busy", 32'(busy), 0);
        chk("t5r no done", 32'(done), 0);

        // Four-register instance: start wins over abort in IDLE.
        ready4 = 1'b1;
        start4 = 1'b1;
        abort4 = 1'b1;
        tick();
        start4 = 1'b0;
        abort4 = 1'b0;
        chk("t6 start beats abort", 32'(busy4), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6 b%0d valid", i), 32'(valid4), 1);
            chk($sformatf("t6 b%0d addr", i), 32'(addr4), 32'(i));
            chk($sformatf("t6 b%0d data", i), 32'(data4), 32'h2000 + 32'(i));
            tick();
        end
        chk("t6 done", 32'(done4), 1);
        chk("t6 end valid", 32'(valid4), 0);
        tick();
        chk("t6 done one cycle", 32'(done4), 0);
        chk("t6 no wrap valid", 32'(valid4), 0);
        chk("t6 busy", 32'(busy4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side companion to the core's 16-bit register file.
- On a start pulse, it walks the read port across every register, from R0 to R(NUM_REGS-1).
- Each value is presented to a downstream consumer on a valid/ready stream, tagged with its register address.
- Used for debug readout and register-file verification. It never writes the register file.

Parameters:
- DATA_W, 16, width of a register word.
- NUM_REGS, 8, number of registers scanned; must be 2 or more.
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a dump; sampled in IDLE only.
- abort  in  1  synchronous cancel of a dump in progress.
- rd_addr  out  ADDR_W  read address to the register file.
- rd_data  in  DATA_W  register file read data; combinational from rd_addr, valid in the same cycle.
- out_valid  out  1  out_data/out_addr hold a word.
- out_ready  in  1  consumer accepts the word when out_valid=1.
- out_data  out  DATA_W  captured register value.
- out_addr  out  ADDR_W  register index of out_data.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, rd_addr=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0. Reset mid-dump discards everything, with no done pulse.
- States: IDLE, LOAD, STREAM. busy=1 in LOAD and STREAM.
- IDLE:
  - rd_addr=0.
  - start=1 -> idx<=0, go to LOAD.
  - start is ignored in any other state.
- LOAD:
  - rd_addr=idx.
  - At the edge: out_data<=rd_data, out_addr<=idx, out_valid<=1, go to STREAM.
  - Latency: the first word is valid 2 cycles after the start edge.
- STREAM:
  - rd_addr=idx+1 (prefetch address; drives 0 when idx=NUM_REGS-1).
  - Handshake is out_valid & out_ready.
  - Handshake with idx<NUM_REGS-1: out_data<=rd_data, out_addr<=idx+1, idx<=idx+1, out_valid stays 1. Throughput is one word per cycle under continuous ready.
  - Handshake with idx=NUM_REGS-1: out_valid<=0, done<=1 for exactly one cycle, go to IDLE.
  - No handshake: out_data/out_addr/out_valid hold stable. AXI-style rule: once asserted, out_valid never drops without a handshake, except on abort or reset.
- abort=1 in LOAD or STREAM:
  - Next edge: out_valid<=0, IDLE, no done.
  - Abort wins over a simultaneous handshake; the consumer may count that word as transferred.
  - abort in IDLE has no effect; abort and start together in IDLE: start is accepted.
- Coherency: each word reflects the register value at its own capture edge. Writes during a dump are seen only by registers not yet captured. There is no snapshot.
- done and a new start in the same cycle: start is accepted (state is already IDLE).
- Widths: idx is ADDR_W bits. The idx+1 comparison is made against NUM_REGS-1 before increment, so no wrap occurs when NUM_REGS=2**ADDR_W.

Decomposition:
- Shared core package:
  - DATA_W and ADDR_W defaults (shared with the register file).
  - NUM_REGS.
  - State encoding constants IDLE=2'd0, LOAD=2'd1, STREAM=2'd2.
- No sub-module: FSM, index counter and output holding register live in one module, roughly 150 lines.

Test Plan:
- Register file preloaded R0..R7 = 16'h1000+i, out_ready held 1, start pulse -> out_valid from cycle+2 for 8 consecutive cycles; (out_addr,out_data) = (0,1000)...(7,1007); done pulses one cycle after the last beat; busy low after.
- Same preload, out_ready toggled 1,0,0,1,... -> out_data/out_addr stable while stalled; sequence complete, in order, no duplicates; exactly one done.
- Write R5=16'hBEEF while word 2 is stalled -> R5 streamed as BEEF; words 0-2 keep their old values.
- abort asserted during word 3 with out_ready=1 -> out_valid=0 next cycle, busy=0, no done; a new start re-dumps from R0.
- rst asserted mid-STREAM (asynchronous, between edges) -> all outputs zero immediately, state IDLE; start pulsed during the dump (after acceptance) -> ignored, only 8 words emitted.
- NUM_REGS=4, ADDR_W=2, continuous ready -> 4 words, addr 3 is last, done pulses, no wrap to addr 0.
